// File: rtl/pwm_multi_if.sv
// pwm_multi_if: register-bus signals for the pwm_multi block.
// The master drives the access, the slave returns read data.
interface pwm_multi_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA
    );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: NCH-channel PWM with shadowed period/prescale/duty.
// Optional macro PWM_IRQ_EN adds STATUS bit0 and the IRQ output.
module pwm_multi #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    pwm_multi_if.slave     apb,
`ifdef PWM_IRQ_EN
    output logic           IRQ,
`endif
    output logic [NCH-1:0] PWM_OUT
);

    logic                 r_en;
    logic [CNT_W-1:0]     r_period_sh;
    logic [CNT_W-1:0]     r_presc_sh;
    logic [CNT_W-1:0]     r_duty_sh [NCH];
    logic [NCH-1:0]       r_pol;
    logic [CNT_W-1:0]     r_period;
    logic [CNT_W-1:0]     r_presc;
    logic [CNT_W-1:0]     r_duty [NCH];
    logic [CNT_W-1:0]     r_pcnt;
    logic [CNT_W-1:0]     r_cnt;
    logic [NCH-1:0]       r_out;
    logic                 w_wr;
    logic                 w_tick;
    logic                 w_pend;
    logic [NCH-1:0]       w_raw;
    logic [7:0]           w_rdata;

    assign w_wr   = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign w_tick = r_en && (r_pcnt == r_presc);
    assign w_pend = w_tick && (r_cnt == r_period);

    // Shadow and control registers written from the bus
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_en        <= 1'b0;
            r_period_sh <= CNT_W'(9);
            r_presc_sh  <= '0;
            r_pol       <= '0;
            for (int n = 0; n < NCH; n++) r_duty_sh[n] <= CNT_W'(5);
        end else if (w_wr) begin
            case (apb.PADDR)
                8'h00:   r_en        <= apb.PWDATA[0];
                8'h01:   r_period_sh <= apb.PWDATA[CNT_W-1:0];
                8'h02:   r_presc_sh  <= apb.PWDATA[CNT_W-1:0];
                8'h03:   r_pol       <= apb.PWDATA[NCH-1:0];
                default: ;
            endcase
            for (int n = 0; n < NCH; n++) begin
                if (apb.PADDR == 8'(16 + n))
                    r_duty_sh[n] <= apb.PWDATA[CNT_W-1:0];
            end
        end
    end

    // Prescaler, period counter and period-end load of active registers
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_pcnt   <= '0;
            r_cnt    <= '0;
            r_period <= CNT_W'(9);
            r_presc  <= '0;
            for (int n = 0; n < NCH; n++) r_duty[n] <= CNT_W'(5);
        end else if (!r_en) begin
            r_pcnt   <= '0;
            r_cnt    <= '0;
            r_period <= r_period_sh;
            r_presc  <= r_presc_sh;
            for (int n = 0; n < NCH; n++) r_duty[n] <= r_duty_sh[n];
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + CNT_W'(1);
            if (w_tick) r_cnt <= w_pend ? '0 : r_cnt + CNT_W'(1);
            if (w_pend) begin
                r_period <= r_period_sh;
                r_presc  <= r_presc_sh;
                for (int n = 0; n < NCH; n++) r_duty[n] <= r_duty_sh[n];
            end
        end
    end

    // Raw duty compare per channel
    always_comb begin
        w_raw = '0;
        for (int n = 0; n < NCH; n++)
            w_raw[n] = r_en && (r_cnt < r_duty[n]);
    end

    // Registered, polarity-adjusted outputs
    always_ff @(posedge PCLK) begin
        if (!PRESETn) r_out <= '0;
        else          r_out <= w_raw ^ r_pol;
    end

    assign PWM_OUT = r_out;

`ifdef PWM_IRQ_EN
    logic r_status;

    // Period-end flag; a set on the same edge beats a clear
    always_ff @(posedge PCLK) begin
        if (!PRESETn)
            r_status <= 1'b0;
        else if (w_pend)
            r_status <= 1'b1;
        else if (w_wr && apb.PADDR == 8'h04 && apb.PWDATA[0])
            r_status <= 1'b0;
    end

    assign IRQ = r_status;
`endif

    // Combinational read mux, zero outside a read
    always_comb begin
        w_rdata = '0;
        if (apb.PSEL && !apb.PWRITE) begin
            case (apb.PADDR)
                8'h00:   w_rdata[0]         = r_en;
                8'h01:   w_rdata[CNT_W-1:0] = r_period_sh;
                8'h02:   w_rdata[CNT_W-1:0] = r_presc_sh;
                8'h03:   w_rdata[NCH-1:0]   = r_pol;
`ifdef PWM_IRQ_EN
                8'h04:   w_rdata[0]         = r_status;
`endif
                default: ;
            endcase
            for (int n = 0; n < NCH; n++) begin
                if (apb.PADDR == 8'(16 + n))
                    w_rdata[CNT_W-1:0] = r_duty_sh[n];
            end
        end
    end

    assign apb.PRDATA = w_rdata;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi.
// Builds with or without PWM_IRQ_EN.
module tb_pwm_multi;

    logic       PCLK;
    logic       PRESETn;
    logic [3:0] pwm;
`ifdef PWM_IRQ_EN
    logic       irq;
`endif
    int         n_cmp;
    int         n_bad;

    pwm_multi_if bus();

    pwm_multi #(.NCH(4), .CNT_W(8)) u_dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus),
`ifdef PWM_IRQ_EN
        .IRQ     (irq),
`endif
        .PWM_OUT (pwm)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 8'h00;
        bus.PWDATA  = 8'h00;
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive_wr(input logic [7:0] a, input logic [7:0] d);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = a;
        bus.PWDATA  = d;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] d);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = a;
        bus.PWDATA  = d;
        step();
        bus.PENABLE = 1'b1;
        step();
        idle();
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [7:0] d);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = a;
        #1;
        d = bus.PRDATA;
        idle();
        step();
    endtask

    task automatic do_reset();
        idle();
        PRESETn = 1'b0;
        step();
        step();
        PRESETn = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        n_cmp++;
        if (pwm !== 4'h0) begin
            n_bad++;
            $display("FAIL rst_pwm got %h want 0", pwm);
        end
`ifdef PWM_IRQ_EN
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_irq got %b want 0", irq);
        end
`endif
        apb_rd(8'h00, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL rst_ctrl got %h want 00", d); end
        apb_rd(8'h01, d);
        n_cmp++;
        if (d !== 8'h09) begin n_bad++; $display("FAIL rst_period got %h want 09", d); end
        apb_rd(8'h02, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL rst_presc got %h want 00", d); end
        apb_rd(8'h03, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL rst_pol got %h want 00", d); end
        apb_rd(8'h13, d);
        n_cmp++;
        if (d !== 8'h05) begin n_bad++; $display("FAIL rst_duty3 got %h want 05", d); end
    endtask

    task automatic test_regmap();
        logic [7:0] d;
        do_reset();
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 8'h01;
        bus.PWDATA  = 8'h22;
        #1;
        n_cmp++;
        if (bus.PRDATA !== 8'h00) begin
            n_bad++;
            $display("FAIL rd_on_write got %h want 00", bus.PRDATA);
        end
        step();
        idle();
        apb_rd(8'h01, d);
        n_cmp++;
        if (d !== 8'h09) begin n_bad++; $display("FAIL no_penable got %h want 09", d); end
        apb_wr(8'h05, 8'hFF);
        apb_rd(8'h05, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL unmapped got %h want 00", d); end
        apb_wr(8'h14, 8'h03);
        apb_rd(8'h14, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL duty4 got %h want 00", d); end
        apb_wr(8'h04, 8'h01);
        apb_rd(8'h04, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL status got %h want 00", d); end
        apb_wr(8'h12, 8'hA7);
        apb_rd(8'h12, d);
        n_cmp++;
        if (d !== 8'hA7) begin n_bad++; $display("FAIL duty2_rw got %h want a7", d); end
        apb_wr(8'h02, 8'h3C);
        apb_rd(8'h02, d);
        n_cmp++;
        if (d !== 8'h3C) begin n_bad++; $display("FAIL presc_rw got %h want 3c", d); end
    endtask

    task automatic test_default();
        logic [3:0] exp;
        do_reset();
        apb_wr(8'h00, 8'h01);
        for (int i = 0; i < 20; i++) begin
            step();
            exp = ((i % 10) < 5) ? 4'hF : 4'h0;
            n_cmp++;
            if (pwm !== exp) begin
                n_bad++;
                $display("FAIL dflt[%0d] got %h want %h", i, pwm, exp);
            end
        end
    endtask

    task automatic test_prescale();
        logic [3:0] exp;
        do_reset();
        apb_wr(8'h01, 8'h03);
        apb_wr(8'h02, 8'h01);
        apb_wr(8'h10, 8'h01);
        apb_wr(8'h11, 8'h00);
        apb_wr(8'h12, 8'h04);
        apb_wr(8'h00, 8'h01);
        for (int i = 0; i < 16; i++) begin
            step();
            exp = {3'b110, ((i % 8) < 2)};
            n_cmp++;
            if (pwm !== exp) begin
                n_bad++;
                $display("FAIL presc[%0d] got %h want %h", i, pwm, exp);
            end
        end
    endtask

    task automatic test_duty_shadow();
        logic [3:0] exp;
        logic       c0;
        do_reset();
        apb_wr(8'h00, 8'h01);
        for (int i = 0; i < 24; i++) begin
            if (i == 2) drive_wr(8'h10, 8'h02);
            else        idle();
            step();
            c0  = (i < 10) ? ((i % 10) < 5) : ((i % 10) < 2);
            exp = {{3{(i % 10) < 5}}, c0};
            n_cmp++;
            if (pwm !== exp) begin
                n_bad++;
                $display("FAIL duty_sh[%0d] got %h want %h", i, pwm, exp);
            end
        end
        idle();
    endtask

    task automatic test_polarity();
        logic [3:0] exp;
        do_reset();
        apb_wr(8'h03, 8'h01);
        step();
        n_cmp++;
        if (pwm !== 4'h1) begin
            n_bad++;
            $display("FAIL pol_idle got %h want 1", pwm);
        end
        apb_wr(8'h00, 8'h01);
        for (int i = 0; i < 20; i++) begin
            step();
            exp = (((i % 10) < 5) ? 4'hF : 4'h0) ^ 4'h1;
            n_cmp++;
            if (pwm !== exp) begin
                n_bad++;
                $display("FAIL pol[%0d] got %h want %h", i, pwm, exp);
            end
        end
    endtask

    task automatic test_period_shrink();
        logic [3:0] exp;
        logic [7:0] d;
        do_reset();
        apb_wr(8'h00, 8'h01);
        for (int i = 0; i < 22; i++) begin
            if (i == 7) drive_wr(8'h01, 8'h03);
            else        idle();
            step();
            exp = (i >= 10 || i < 5) ? 4'hF : 4'h0;
            n_cmp++;
            if (pwm !== exp) begin
                n_bad++;
                $display("FAIL shrink[%0d] got %h want %h", i, pwm, exp);
            end
        end
        idle();
        apb_rd(8'h01, d);
        n_cmp++;
        if (d !== 8'h03) begin n_bad++; $display("FAIL shrink_rd got %h want 03", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        do_reset();
        apb_wr(8'h10, 8'h02);
        apb_wr(8'h01, 8'h07);
        apb_wr(8'h00, 8'h01);
        for (int i = 0; i < 6; i++) step();
        PRESETn = 1'b0;
        drive_wr(8'h01, 8'h33);
        step();
        PRESETn = 1'b1;
        idle();
        n_cmp++;
        if (pwm !== 4'h0) begin
            n_bad++;
            $display("FAIL rstmid_pwm got %h want 0", pwm);
        end
`ifdef PWM_IRQ_EN
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_irq got %b want 0", irq);
        end
`endif
        apb_rd(8'h01, d);
        n_cmp++;
        if (d !== 8'h09) begin n_bad++; $display("FAIL rstmid_period got %h want 09", d); end
        apb_rd(8'h10, d);
        n_cmp++;
        if (d !== 8'h05) begin n_bad++; $display("FAIL rstmid_duty0 got %h want 05", d); end
        apb_rd(8'h00, d);
        n_cmp++;
        if (d !== 8'h00) begin n_bad++; $display("FAIL rstmid_ctrl got %h want 00", d); end
        step();
        n_cmp++;
        if (pwm !== 4'h0) begin
            n_bad++;
            $display("FAIL rstmid_hold got %h want 0", pwm);
        end
    endtask

`ifdef PWM_IRQ_EN
    task automatic test_irq();
        logic e;
        do_reset();
        apb_wr(8'h00, 8'h01);
        for (int i = 0; i < 26; i++) begin
            if (i == 12 || i == 19) drive_wr(8'h04, 8'h01);
            else                    idle();
            step();
            e = (i >= 9 && i < 12) || (i >= 19);
            n_cmp++;
            if (irq !== e) begin
                n_bad++;
                $display("FAIL irq[%0d] got %b want %b", i, irq, e);
            end
        end
        idle();
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        PRESETn = 1'b0;
        idle();
        test_reset();
        test_regmap();
        test_default();
        test_prescale();
        test_duty_shadow();
        test_polarity();
        test_period_shrink();
        test_reset_mid();
`ifdef PWM_IRQ_EN
        test_irq();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
